// File: rtl/if_prefetch.sv
// Instruction-fetch stage: serially loadable instruction memory, fetch PC running ahead of
// decode, and a FIFO prefetch queue that decode drains one word per cycle.
module if_prefetch #(
    parameter int unsigned PC_SIZE            = 32,
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
    parameter int unsigned QUEUE_DEPTH        = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic                           i_halt,
    input  logic                           i_enable,
    input  logic                           i_stall,
    input  logic                           i_write_mem,
    input  logic [PC_SIZE-1:0]             i_instruction,
    input  logic                           i_next_pc_src,
    input  logic [PC_SIZE-1:0]             i_next_not_seq_pc,
    output logic                           o_full_mem,
    output logic                           o_empty_mem,
    output logic                           o_valid,
    output logic [PC_SIZE-1:0]             o_instruction,
    output logic [PC_SIZE-1:0]             o_next_seq_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count
);

    localparam int unsigned MemAw = (MEM_SIZE_IN_WORDS > 1) ? $clog2(MEM_SIZE_IN_WORDS) : 1;
    localparam int unsigned PtrW  = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam int unsigned QAw   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW  = QAw + 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_t;

    state_t               r_state, w_state_next;
    logic [PtrW-1:0]      r_load_ptr, w_load_ptr_next;
    logic                 r_write_prev;
    logic [PC_SIZE-1:0]   r_fpc, w_fpc_next;
    logic [QAw-1:0]       r_head, w_head_next;
    logic [QAw-1:0]       r_tail, w_tail_next;
    logic [CntW-1:0]      r_count, w_count_next;
    logic                 r_valid, w_valid_next;
    logic [PC_SIZE-1:0]   r_instr, w_instr_next;
    logic [PC_SIZE-1:0]   r_nspc, w_nspc_next;

    logic [PC_SIZE-1:0]   r_mem  [MEM_SIZE_IN_WORDS];
    logic [PC_SIZE-1:0]   r_q_word [QUEUE_DEPTH];
    logic [PC_SIZE-1:0]   r_q_pc   [QUEUE_DEPTH];

    logic                 w_restart;
    logic                 w_active;
    logic                 w_load;
    logic                 w_mem_full;
    logic                 w_q_full;
    logic                 w_q_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_redirect;
    logic [PC_SIZE-1:0]   w_fetch_idx;
    logic                 w_idx_ok;

    assign w_mem_full  = (r_load_ptr == PtrW'(MEM_SIZE_IN_WORDS));
    assign w_q_full    = (r_count == CntW'(QUEUE_DEPTH));
    assign w_q_empty   = (r_count == '0);
    assign w_fetch_idx = r_fpc / PC_SIZE'(WORD_SIZE_IN_BYTES);
    assign w_idx_ok    = (w_fetch_idx < PC_SIZE'(MEM_SIZE_IN_WORDS));

    // Loading is edge-triggered on i_write_mem so a held level writes a single word.
    assign w_load = !i_reset && (r_state == StIdle) && i_write_mem && !r_write_prev
                    && !w_mem_full;

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_active     = 1'b0;
        if (i_enable) begin
            unique case (r_state)
                StIdle, StHalted: begin
                    if (i_start && !i_halt) begin
                        w_state_next = StRun;
                        w_restart    = 1'b1;
                    end
                end
                StRun: begin
                    if (i_halt) begin
                        w_state_next = StHalted;
                    end else if (i_start) begin
                        w_restart = 1'b1;
                    end else begin
                        w_active = 1'b1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    assign w_redirect = w_active && i_next_pc_src;
    assign w_push     = w_active && !i_next_pc_src && !w_q_full && w_idx_ok;
    assign w_pop      = w_active && !i_next_pc_src && !i_stall && !w_q_empty;

    always_comb begin
        w_load_ptr_next = r_load_ptr;
        w_fpc_next      = r_fpc;
        w_head_next     = r_head;
        w_tail_next     = r_tail;
        w_count_next    = r_count;
        w_valid_next    = r_valid;
        w_instr_next    = r_instr;
        w_nspc_next     = r_nspc;

        if (w_load) begin
            w_load_ptr_next = r_load_ptr + PtrW'(1);
        end

        if (w_restart) begin
            w_fpc_next   = '0;
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else if (w_redirect) begin
            w_fpc_next   = i_next_not_seq_pc;
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
            w_valid_next = 1'b0;
            w_instr_next = '0;
        end else if (w_active) begin
            if (w_push) begin
                w_tail_next = r_tail + QAw'(1);
                w_fpc_next  = r_fpc + PC_SIZE'(WORD_SIZE_IN_BYTES);
            end
            if (w_pop) begin
                w_head_next  = r_head + QAw'(1);
                w_valid_next = 1'b1;
                w_instr_next = r_q_word[r_head];
                w_nspc_next  = r_q_pc[r_head] + PC_SIZE'(WORD_SIZE_IN_BYTES);
            end else if (!i_stall) begin
                // Bubble: issue a NOP but keep the last sequential PC.
                w_valid_next = 1'b0;
                w_instr_next = '0;
            end
            w_count_next = r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_load_ptr   <= '0;
            r_write_prev <= 1'b0;
            r_fpc        <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_nspc       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_load_ptr   <= w_load_ptr_next;
            r_write_prev <= i_write_mem;
            r_fpc        <= w_fpc_next;
            r_head       <= w_head_next;
            r_tail       <= w_tail_next;
            r_count      <= w_count_next;
            r_valid      <= w_valid_next;
            r_instr      <= w_instr_next;
            r_nspc       <= w_nspc_next;
        end
    end

    // Storage arrays carry no reset; program contents survive i_reset.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_mem[r_load_ptr[MemAw-1:0]] <= i_instruction;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_word[r_tail] <= r_mem[w_fetch_idx[MemAw-1:0]];
            r_q_pc[r_tail]   <= r_fpc;
        end
    end

    assign o_full_mem    = w_mem_full;
    assign o_empty_mem   = (r_load_ptr == '0);
    assign o_valid       = r_valid;
    assign o_instruction = r_instr;
    assign o_next_seq_pc = r_nspc;
    assign o_queue_count = r_count;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed vector table and hand sequences plus random stimulus,
// all checked against a queue-based behavioural model.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst, start, halt, en, stall, wr, redir;
    logic [31:0] instr_in, target;
    logic        full_mem, empty_mem, valid;
    logic [31:0] instr_out, nspc;
    logic [2:0]  qcount;

    always #5 clk = ~clk;

    if_prefetch #(
        .PC_SIZE            (32),
        .WORD_SIZE_IN_BYTES (4),
        .MEM_SIZE_IN_WORDS  (8),
        .QUEUE_DEPTH        (4)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_start           (start),
        .i_halt            (halt),
        .i_enable          (en),
        .i_stall           (stall),
        .i_write_mem       (wr),
        .i_instruction     (instr_in),
        .i_next_pc_src     (redir),
        .i_next_not_seq_pc (target),
        .o_full_mem        (full_mem),
        .o_empty_mem       (empty_mem),
        .o_valid           (valid),
        .o_instruction     (instr_out),
        .o_next_seq_pc     (nspc),
        .o_queue_count     (qcount)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=run, 2=halted; prefetch queue as an SV queue.
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    int          m_mode = 0;
    logic [31:0] m_mem [8];
    int          m_ptr = 0;
    logic        m_prev = 1'b0;
    logic [31:0] m_fpc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_nspc = '0;

    task automatic model_step();
        int     had;
        entry_t hd;
        entry_t e;
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_prev = 1'b0; m_fpc = '0; mq.delete();
            m_valid = 1'b0; m_instr = '0; m_nspc = '0;
            return;
        end
        if (m_mode == 0 && wr && !m_prev && m_ptr < 8) begin
            m_mem[m_ptr] = instr_in;
            m_ptr++;
        end
        m_prev = wr;
        if (!en) return;
        if (start && !halt) begin
            m_mode = 1; m_fpc = '0; mq.delete();
        end else if (halt && m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 1) begin
            if (redir) begin
                mq.delete(); m_fpc = target; m_valid = 1'b0; m_instr = '0;
            end else begin
                had = mq.size();
                if (had > 0) hd = mq[0];
                if (had < 4 && (m_fpc / 4) < 8) begin
                    e.word = m_mem[m_fpc / 4];
                    e.pc   = m_fpc;
                    mq.push_back(e);
                    m_fpc = m_fpc + 4;
                end
                if (!stall) begin
                    if (had > 0) begin
                        void'(mq.pop_front());
                        m_valid = 1'b1; m_instr = hd.word; m_nspc = hd.pc + 4;
                    end else begin
                        m_valid = 1'b0; m_instr = '0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model_valid", valid, m_valid);
        chk("model_instr", instr_out, m_instr);
        chk("model_nspc", nspc, m_nspc);
        chk("model_count", qcount, mq.size());
        chk("model_full_mem", full_mem, m_ptr == 8);
        chk("model_empty_mem", empty_mem, m_ptr == 0);
    endtask

    task automatic idle_in();
        rst = 0; start = 0; halt = 0; en = 1; stall = 0; wr = 0; redir = 0;
        instr_in = '0; target = '0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input int cnt);
        chk({tag, "_valid"}, valid, v);
        chk({tag, "_instr"}, instr_out, ins);
        chk({tag, "_nspc"}, nspc, pc);
        chk({tag, "_count"}, qcount, cnt);
    endtask

    typedef struct {
        logic        start, stall, redir;
        logic [31:0] target;
        logic        v;
        logic [31:0] ins, pc;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic st, input logic r, input logic [31:0] t,
                                input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input int cnt);
        vec_t x;
        x.start = s; x.stall = st; x.redir = r; x.target = t;
        x.v = v; x.ins = ins; x.pc = pc; x.cnt = cnt;
        return x;
    endfunction

    vec_t tbl[19];

    initial begin
        idle_in();

        // Reset state
        rst = 1;
        step();
        step();
        chk_out("reset", 1'b0, 32'h0, 32'h0, 0);
        chk("reset_empty_mem", empty_mem, 1'b1);
        chk("reset_full_mem", full_mem, 1'b0);
        rst = 0;

        // Load 8 words with random pulse widths, then a 9th that must be ignored
        for (int k = 0; k < 9; k++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 2);
            instr_in = (k < 8) ? 32'(32'hA0 + k) : 32'hBB;
            wr = 1;
            repeat (hi) step();
            wr = 0;
            repeat (lo) step();
            if (k == 0) chk("empty_after_1", empty_mem, 1'b0);
        end
        chk("full_after_9", full_mem, 1'b1);

        // Start, stall to full, release, redirect under stall, drain
        tbl[0]  = mk(1, 0, 0, 0,     0, 32'h00, 32'h00, 0);
        tbl[1]  = mk(0, 0, 0, 0,     0, 32'h00, 32'h00, 1);
        tbl[2]  = mk(0, 0, 0, 0,     1, 32'hA0, 32'h04, 1);
        tbl[3]  = mk(0, 0, 0, 0,     1, 32'hA1, 32'h08, 1);
        tbl[4]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 2);
        tbl[5]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 3);
        tbl[6]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 4);
        tbl[7]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 4);
        tbl[8]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 4);
        tbl[9]  = mk(0, 1, 0, 0,     1, 32'hA1, 32'h08, 4);
        tbl[10] = mk(0, 0, 0, 0,     1, 32'hA2, 32'h0C, 3);
        tbl[11] = mk(0, 1, 0, 0,     1, 32'hA2, 32'h0C, 4);
        tbl[12] = mk(0, 1, 1, 32'h14, 0, 32'h00, 32'h0C, 0);
        tbl[13] = mk(0, 0, 0, 0,     0, 32'h00, 32'h0C, 1);
        tbl[14] = mk(0, 0, 0, 0,     1, 32'hA5, 32'h18, 1);
        tbl[15] = mk(0, 0, 0, 0,     1, 32'hA6, 32'h1C, 1);
        tbl[16] = mk(0, 0, 0, 0,     1, 32'hA7, 32'h20, 0);
        tbl[17] = mk(0, 0, 0, 0,     0, 32'h00, 32'h20, 0);
        tbl[18] = mk(0, 0, 0, 0,     0, 32'h00, 32'h20, 0);
        for (int i = 0; i < 19; i++) begin
            idle_in();
            start = tbl[i].start; stall = tbl[i].stall;
            redir = tbl[i].redir; target = tbl[i].target;
            step();
            chk_out($sformatf("row%0d", i), tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].cnt);
        end

        // Halt/restart and enable freeze
        idle_in(); halt = 1; step(); chk_out("halt0", 0, 32'h0, 32'h20, 0);
        idle_in(); start = 1; step();
        idle_in(); step(); chk_out("rs_e1", 0, 32'h0, 32'h20, 1);
        step(); chk_out("rs_a0", 1, 32'hA0, 32'h04, 1);
        step(); step(); chk_out("rs_a2", 1, 32'hA2, 32'h0C, 1);
        halt = 1; step(); halt = 0;
        for (int i = 0; i < 4; i++) step();
        chk_out("halt_frozen", 1, 32'hA2, 32'h0C, 1);
        start = 1; step(); start = 0;
        chk_out("restart_e0", 1, 32'hA2, 32'h0C, 0);
        step(); chk_out("restart_e1", 0, 32'h0, 32'h0C, 1);
        step(); chk_out("restart_e2", 1, 32'hA0, 32'h04, 1);
        stall = 1; step(); step(); stall = 0;
        chk_out("stall2", 1, 32'hA0, 32'h04, 3);
        en = 0; step(); step(); step(); en = 1;
        chk_out("disabled", 1, 32'hA0, 32'h04, 3);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("stream%0d_instr", k), instr_out, 32'(32'hA0 + k));
            chk($sformatf("stream%0d_nspc", k), nspc, 32'(4 * (k + 1)));
        end
        step(); chk_out("drained", 0, 32'h0, 32'h20, 0);

        // Reset mid-run, then out-of-range redirect
        start = 1; step(); start = 0; step(); step();
        rst = 1; step(); rst = 0;
        chk_out("midrun_reset", 0, 32'h0, 32'h0, 0);
        chk("midrun_empty_mem", empty_mem, 1'b1);
        start = 1; step(); start = 0;
        redir = 1; target = 32'h40; step(); redir = 0;
        for (int i = 0; i < 4; i++) step();
        chk_out("oor_redirect", 0, 32'h0, 32'h0, 0);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 15) == 0);
            halt     = ($urandom_range(0, 23) == 0);
            en       = ($urandom_range(0, 7) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            wr       = ($urandom_range(0, 2) == 0);
            instr_in = $urandom;
            redir    = ($urandom_range(0, 7) == 0);
            target   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 47));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
